morra_raccolta_mosse: RTL
=========================

// Module: morra_raccolta_mosse
// PURPOSE
//  Upstream input stage for the morra game FSM. Collects each player's move through an independent valid/ready handshake.
//  Holds the first move until the other arrives, then presents both on primo/secondo for exactly one cycle.
//  Drives 2'b00 (invalid move) at all other times, so the downstream FSM never counts a manche twice.
//  Also generates the one-cycle inizia pulse, with {primo,secondo} carrying the manche-count configuration.
// PARAMETERS
//  TIMEOUT_CYC  1000  cycles to wait for the second move after the first is accepted (used only with the optional feature)
//  CNT_W        10    width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk         in   1  clock, all logic on posedge
//  rst_n       in   1  synchronous, active-low reset
//  start       in   1  request a new game (level, sampled each cycle)
//  cfg_manche  in   4  manche configuration, captured when start is sampled high
//  p1_valid    in   1  player 1 move offered
//  p1_mossa    in   2  player 1 move: 01 sasso, 10 carta, 11 forbici; 00 is illegal
//  p1_ready    out  1  player 1 slot empty and accepting
//  p2_valid    in   1  player 2 move offered
//  p2_mossa    in   2  player 2 move, same encoding as p1_mossa
//  p2_ready    out  1  player 2 slot empty and accepting
//  partita     in   2  game result from the downstream FSM; nonzero means the game is over
//  primo       out  2  move 1 to the downstream FSM
//  secondo     out  2  move 2 to the downstream FSM
//  inizia      out  1  one-cycle start/reset pulse to the downstream FSM
//  attivo      out  1  high in RACCOLTA and EMETTI
// BEHAVIOUR
//  All outputs are registered; every output reflects the current state.
//  Reset (rst_n=0 at posedge): state IDLE; primo=secondo=00; inizia=0; p1_ready=p2_ready=0; attivo=0;
//   both slots cleared; timeout counter cleared.
//  States: IDLE, INIT, RACCOLTA, EMETTI, FINE.
//  Transition priority each cycle: rst_n > start > partita!=00 > normal transition.
//  start=1 in any state except INIT -> INIT:
//   - captures cfg_manche
//   - clears both slots and the timeout counter; any half-collected pair is discarded
//  INIT (1 cycle): inizia=1, {primo,secondo}=captured cfg_manche, readies=0; -> RACCOLTA.
//  RACCOLTA: pX_ready=1 iff slot X empty.
//   - Accept on pX_valid & pX_ready & pX_mossa!=00.
//   - A 00 offer is not accepted; ready stays high.
//   - primo=secondo=00.
//   - Next state is EMETTI in the cycle after both slots are full.
//   - Simultaneous acceptance of both moves in one cycle -> EMETTI next cycle.
//   - A full slot ignores further offers: its ready is 0 and the held value is never overwritten.
//  EMETTI (1 cycle): primo=slot1, secondo=slot2; readies=0; slots and counter cleared; -> RACCOLTA.
//  partita!=00 sampled in RACCOLTA or EMETTI -> FINE:
//   - the pending emission is dropped, slots are cleared
//   - FINE: readies=0, primo=secondo=00, attivo=0; stays until start.
//  partita is ignored in IDLE, INIT and FINE.
//  Downstream latency: a move pair is visible one cycle after the second acceptance, for exactly one cycle.
// CONFIGURATION
//  MORRA_TIMEOUT_EN defined:
//   - CNT_W counter starts at 0 on the cycle the first slot fills and increments each cycle in RACCOLTA.
//   - When it reaches TIMEOUT_CYC-1 with one slot still empty -> EMETTI, with the empty slot emitted as 00.
//   - This yields an invalid manche downstream; the counter is then cleared.
//   - If the second move is accepted in the same cycle the limit is reached, the real move wins.
//  MORRA_TIMEOUT_EN undefined:
//   - No counter is instantiated; RACCOLTA waits indefinitely. TIMEOUT_CYC and CNT_W are unused.
// TESTING
//  Start and config: rst_n low 2 cycles, then start=1 with cfg_manche=4'b0110
//   -> next cycle inizia=1, primo=01, secondo=10; following cycle attivo=1, p1_ready=p2_ready=1.
//  Staggered pair: p1 offers 01 at cycle t, p2 offers 11 at t+3
//   -> p1_ready=0 from t+1; primo=01, secondo=11 only at t+4; 00/00 at t+5; readies=1 again.
//  Simultaneous pair and illegal move:
//   - p1=10, p2=00 in the same cycle -> only p1 accepted, p2_ready stays 1.
//   - p2=10 two cycles later -> one emission 10/10.
//  Game over and restart:
//   - partita=01 while p1 slot is full -> FINE, readies=0, no emission.
//   - start=1 -> INIT, inizia=1, slots empty.
//  Timeout (MORRA_TIMEOUT_EN, TIMEOUT_CYC=8): p1 offers 11, p2 silent -> emission 11/00 after 8 cycles.
//   Without the macro, no emission after 100 cycles.
//  Reset mid-collection: rst_n=0 with p2 slot full -> all outputs zero next cycle; after start, the old move is never emitted.

Source files
------------

// File: rtl/morra_raccolta_mosse_if.sv
// Move-collection handshake bundle for the morra input stage.
// master = players (offer moves), slave = collector.
interface morra_raccolta_mosse_if;
  logic       p1_valid;
  logic [1:0] p1_mossa;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_mossa;
  logic       p2_ready;

  modport master (
    output p1_valid, p1_mossa,
    output p2_valid, p2_mossa,
    input  p1_ready, p2_ready
  );

  modport slave (
    input  p1_valid, p1_mossa,
    input  p2_valid, p2_mossa,
    output p1_ready, p2_ready
  );
endinterface

// File: rtl/morra_raccolta_mosse.sv
// Morra move collector: pairs two player moves and emits them once.
// Optional second-move timeout enabled by defining MORRA_TIMEOUT_EN.
module morra_raccolta_mosse #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           cfg_manche,
  input  logic [1:0]           partita,
  morra_raccolta_mosse_if.slave bus,
  output logic [1:0]           primo,
  output logic [1:0]           secondo,
  output logic                 inizia,
  output logic                 attivo
);

  if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cfg_err
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {
    IDLE, INIT, RACCOLTA, EMETTI, FINE
  } stato_t;

  stato_t     stato;
  logic [1:0] slot1;
  logic [1:0] slot2;
  logic [1:0] s1_n;
  logic [1:0] s2_n;
  logic       go_init;
  logic       go_fine;
  logic       scaduto;

  assign go_init = start && (stato != INIT);
  assign go_fine = (partita != 2'b00) &&
                   ((stato == RACCOLTA) || (stato == EMETTI));

  // Slot contents after this cycle's acceptances (00 means empty).
  always_comb begin
    s1_n = slot1;
    s2_n = slot2;
    if (slot1 == 2'b00 && bus.p1_valid && bus.p1_mossa != 2'b00)
      s1_n = bus.p1_mossa;
    if (slot2 == 2'b00 && bus.p2_valid && bus.p2_mossa != 2'b00)
      s2_n = bus.p2_mossa;
  end

`ifdef MORRA_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             in_attesa;

  assign in_attesa = (stato == RACCOLTA) &&
                     ((slot1 != 2'b00) ^ (slot2 != 2'b00));
  assign scaduto   = in_attesa &&
                     (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Counts cycles spent waiting with exactly one slot held.
  always_ff @(posedge clk) begin
    if (!rst_n || go_init || go_fine || !in_attesa)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`else
  assign scaduto = 1'b0;
`endif

  // Collection FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stato        <= IDLE;
      slot1        <= 2'b00;
      slot2        <= 2'b00;
      primo        <= 2'b00;
      secondo      <= 2'b00;
      inizia       <= 1'b0;
      attivo       <= 1'b0;
      bus.p1_ready <= 1'b0;
      bus.p2_ready <= 1'b0;
    end else if (go_init) begin
      stato        <= INIT;
      slot1        <= 2'b00;
      slot2        <= 2'b00;
      primo        <= cfg_manche[3:2];
      secondo      <= cfg_manche[1:0];
      inizia       <= 1'b1;
      attivo       <= 1'b0;
      bus.p1_ready <= 1'b0;
      bus.p2_ready <= 1'b0;
    end else if (go_fine) begin
      stato        <= FINE;
      slot1        <= 2'b00;
      slot2        <= 2'b00;
      primo        <= 2'b00;
      secondo      <= 2'b00;
      inizia       <= 1'b0;
      attivo       <= 1'b0;
      bus.p1_ready <= 1'b0;
      bus.p2_ready <= 1'b0;
    end else begin
      unique case (stato)
        IDLE, FINE: begin
          primo        <= 2'b00;
          secondo      <= 2'b00;
          inizia       <= 1'b0;
          attivo       <= 1'b0;
          bus.p1_ready <= 1'b0;
          bus.p2_ready <= 1'b0;
        end
        INIT, EMETTI: begin
          stato        <= RACCOLTA;
          slot1        <= 2'b00;
          slot2        <= 2'b00;
          primo        <= 2'b00;
          secondo      <= 2'b00;
          inizia       <= 1'b0;
          attivo       <= 1'b1;
          bus.p1_ready <= 1'b1;
          bus.p2_ready <= 1'b1;
        end
        RACCOLTA: begin
          inizia <= 1'b0;
          attivo <= 1'b1;
          if ((s1_n != 2'b00 && s2_n != 2'b00) || scaduto) begin
            stato        <= EMETTI;
            slot1        <= 2'b00;
            slot2        <= 2'b00;
            primo        <= s1_n;
            secondo      <= s2_n;
            bus.p1_ready <= 1'b0;
            bus.p2_ready <= 1'b0;
          end else begin
            slot1        <= s1_n;
            slot2        <= s2_n;
            primo        <= 2'b00;
            secondo      <= 2'b00;
            bus.p1_ready <= (s1_n == 2'b00);
            bus.p2_ready <= (s2_n == 2'b00);
          end
        end
        default: begin
          stato        <= IDLE;
          slot1        <= 2'b00;
          slot2        <= 2'b00;
          primo        <= 2'b00;
          secondo      <= 2'b00;
          inizia       <= 1'b0;
          attivo       <= 1'b0;
          bus.p1_ready <= 1'b0;
          bus.p2_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
